// File: rtl/tetris_pkg.sv
// Shared types for the Tetris keyboard front end: game commands, decoder states, HID codes.
// No logic here; map_key is a pure combinational lookup.
// Not applicable (no handshake).
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_LEFT       = 3'd1,
    CMD_RIGHT      = 3'd2,
    CMD_SOFT_DROP  = 3'd3,
    CMD_ROTATE_CW  = 3'd4,
    CMD_ROTATE_CCW = 3'd5,
    CMD_HARD_DROP  = 3'd6
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DAS_WAIT = 3'd1,
    REPEAT   = 3'd2,
    HOLD     = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // USB HID usage codes (keyboard page)
  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_Q     = 8'h14;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_UP    = 8'h52;

  // Keycode to game command; anything not listed behaves like "no key".
  function automatic cmd_t map_key(input logic [7:0] kc);
    cmd_t c;
    case (kc)
      KC_A, KC_LEFT:  c = CMD_LEFT;
      KC_D, KC_RIGHT: c = CMD_RIGHT;
      KC_S, KC_DOWN:  c = CMD_SOFT_DROP;
      KC_W, KC_UP:    c = CMD_ROTATE_CW;
      KC_Q:           c = CMD_ROTATE_CCW;
      KC_SPACE:       c = CMD_HARD_DROP;
      default:        c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keycode_cmd_decoder.sv
// Turns the held HID keycode into one-cycle game commands with DAS/auto-repeat for movement.
// Latency: keycode change registered at edge k -> cmd_valid high after edge k+1 (two flop stages).
// No backpressure: commands are strobes and the consumer must accept them every cycle.
module keycode_cmd_decoder
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_DELAY  = 8_500_000,
  parameter int unsigned ARR_PERIOD = 2_500_000,
  parameter int unsigned SD_PERIOD  = 1_500_000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       Clk,
  input  logic       Reset_h,
  input  logic [7:0] keycode,
  input  logic       enable,
  output logic       cmd_valid,
  output cmd_t       cmd,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] DAS_LD = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] ARR_LD = CNT_W'(ARR_PERIOD);
  localparam logic [CNT_W-1:0] SD_LD  = CNT_W'(SD_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]       kc_q, kc_d;
  logic [7:0]       kc_prev_q, kc_prev_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cur_cmd_q, cur_cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  cmd_t             cmd_q, cmd_d;

  cmd_t             kc_cmd;
  logic             kc_mapped;
  logic             kc_changed;

  // Input sampling stage and its one-cycle history for change detection.
  always_comb begin
    kc_d      = keycode;
    kc_prev_d = kc_q;
  end

  // Decode the registered keycode.
  always_comb begin
    kc_cmd     = map_key(kc_q);
    kc_mapped  = (kc_cmd != CMD_NONE);
    kc_changed = (kc_q != kc_prev_q);
  end

  // Next-state: a change always takes priority over a timer expiry in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_cmd_d   = cur_cmd_q;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NONE;

    if (!enable) begin
      // A key held while disabled must be released before it can fire.
      state_d   = kc_mapped ? LOCKOUT : IDLE;
      cnt_d     = '0;
      cur_cmd_d = CMD_NONE;
    end else if (state_q == LOCKOUT) begin
      if (!kc_mapped) begin
        state_d = IDLE;
      end
    end else if (kc_changed) begin
      if (kc_mapped) begin
        cmd_valid_d = 1'b1;
        cmd_d       = kc_cmd;
        cur_cmd_d   = kc_cmd;
        case (kc_cmd)
          CMD_LEFT, CMD_RIGHT: begin
            state_d = DAS_WAIT;
            cnt_d   = DAS_LD;
          end
          CMD_SOFT_DROP: begin
            state_d = REPEAT;
            cnt_d   = SD_LD;
          end
          default: begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        endcase
      end else begin
        state_d   = IDLE;
        cnt_d     = '0;
        cur_cmd_d = CMD_NONE;
      end
    end else begin
      case (state_q)
        DAS_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            cmd_valid_d = 1'b1;
            cmd_d       = cur_cmd_q;
            cnt_d       = ARR_LD;
            state_d     = REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        REPEAT: begin
          if (cnt_q == CNT_ONE) begin
            cmd_valid_d = 1'b1;
            cmd_d       = cur_cmd_q;
            cnt_d       = (cur_cmd_q == CMD_SOFT_DROP) ? SD_LD : ARR_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // All state, including the output strobe, resets asynchronously.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      kc_q        <= KC_NONE;
      kc_prev_q   <= KC_NONE;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_cmd_q   <= CMD_NONE;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
    end else begin
      kc_q        <= kc_d;
      kc_prev_q   <= kc_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_cmd_q   <= cur_cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  // Outputs come straight from flops so they are glitch-free.
  always_comb begin
    cmd_valid = cmd_valid_q;
    cmd       = cmd_q;
    key_held  = (state_q == DAS_WAIT) || (state_q == REPEAT) || (state_q == HOLD);
  end

endmodule

// File: tb/tb_keycode_cmd_decoder.sv
// Directed bench for keycode_cmd_decoder with short DAS/ARR/SD periods.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Pulse schedule per key segment is computed from first/gap parameters, not from the DUT.
module tb_keycode_cmd_decoder;
  import tetris_pkg::*;

  logic       Clk;
  logic       Reset_h;
  logic [7:0] keycode;
  logic       enable;
  logic       cmd_valid;
  cmd_t       cmd;
  logic       key_held;

  int n_checks = 0;
  int n_fail   = 0;

  keycode_cmd_decoder #(
    .DAS_DELAY (10),
    .ARR_PERIOD(4),
    .SD_PERIOD (3),
    .CNT_W     (24)
  ) dut (
    .Clk      (Clk),
    .Reset_h  (Reset_h),
    .keycode  (keycode),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .key_held (key_held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pulse at cycle i: first, then first+gap1, then every gap after that.
  function automatic bit is_pulse(input int i, input int first, input int gap1, input int gap);
    if (first < 0) return 1'b0;
    if (i == first) return 1'b1;
    if (gap1 == 0) return 1'b0;
    if (i < first + gap1) return 1'b0;
    return ((i - first - gap1) % gap) == 0;
  endfunction

  task automatic set_kc(input logic [7:0] v);
    @(posedge Clk);
    #1 keycode = v;
  endtask

  // Observe n cycles after a keycode change; held_from < 0 skips key_held checks.
  task automatic watch(input string tag, input int n, input cmd_t c, input int first,
                       input int gap1, input int gap, input int held_from);
    bit   exp_v;
    cmd_t exp_c;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      exp_v = is_pulse(i, first, gap1, gap);
      exp_c = exp_v ? c : CMD_NONE;
      check($sformatf("%s[%0d].valid", tag, i), 32'(cmd_valid), 32'(exp_v));
      check($sformatf("%s[%0d].cmd", tag, i), 32'(cmd), 32'(exp_c));
      if (held_from >= 0 && i >= held_from)
        check($sformatf("%s[%0d].held", tag, i), 32'(key_held), 32'd1);
    end
  endtask

  initial begin
    Reset_h = 1'b1;
    keycode = 8'h00;
    enable  = 1'b1;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst.valid", 32'(cmd_valid), 32'd0);
    check("rst.cmd", 32'(cmd), 32'(CMD_NONE));
    check("rst.held", 32'(key_held), 32'd0);
    @(posedge Clk);
    #1 Reset_h = 1'b0;
    watch("idle", 4, CMD_NONE, -1, 0, 0, -1);
    check("idle.held", 32'(key_held), 32'd0);

    // LEFT: press, DAS of 10, repeat every 4
    set_kc(8'h04);
    watch("left", 30, CMD_LEFT, 2, 10, 4, 2);
    set_kc(8'h00);
    watch("left_rel", 8, CMD_NONE, -1, 0, 0, -1);
    check("left_rel.held", 32'(key_held), 32'd0);

    // HARD_DROP: single shot, held throughout
    set_kc(8'h2C);
    watch("hdrop", 50, CMD_HARD_DROP, 2, 0, 0, 2);
    set_kc(8'h00);
    watch("hdrop_rel", 4, CMD_NONE, -1, 0, 0, -1);

    // SOFT_DROP: no initial delay, every 3
    set_kc(8'h51);
    watch("sdrop", 12, CMD_SOFT_DROP, 2, 3, 3, 2);
    set_kc(8'h00);
    watch("sdrop_rel", 4, CMD_NONE, -1, 0, 0, -1);

    // LEFT then RIGHT landing on the LEFT repeat edge: only RIGHT fires, DAS restarts
    set_kc(8'h04);
    watch("sw_left", 10, CMD_LEFT, 2, 0, 0, 2);
    set_kc(8'h4F);
    watch("sw_right", 18, CMD_RIGHT, 2, 10, 4, 0);
    set_kc(8'h00);
    watch("sw_rel", 4, CMD_NONE, -1, 0, 0, -1);

    // Key pressed while disabled stays locked out after enable returns
    @(posedge Clk);
    #1 begin
      enable  = 1'b0;
      keycode = 8'h1A;
    end
    watch("dis", 6, CMD_NONE, -1, 0, 0, -1);
    check("dis.held", 32'(key_held), 32'd0);
    @(posedge Clk);
    #1 enable = 1'b1;
    watch("lock", 10, CMD_NONE, -1, 0, 0, -1);
    check("lock.held", 32'(key_held), 32'd0);
    set_kc(8'h00);
    watch("lock_rel", 4, CMD_NONE, -1, 0, 0, -1);
    set_kc(8'h1A);
    watch("rot", 8, CMD_ROTATE_CW, 2, 0, 0, 2);
    set_kc(8'h00);
    watch("rot_rel", 4, CMD_NONE, -1, 0, 0, -1);

    // Reset in the middle of a repeat pulse: outputs clear asynchronously
    set_kc(8'h07);
    watch("right", 12, CMD_RIGHT, 2, 10, 4, 2);
    @(posedge Clk);
    #2;
    check("pre_rst.valid", 32'(cmd_valid), 32'd1);
    check("pre_rst.cmd", 32'(cmd), 32'(CMD_RIGHT));
    Reset_h = 1'b1;
    #1;
    check("async_rst.valid", 32'(cmd_valid), 32'd0);
    check("async_rst.cmd", 32'(cmd), 32'(CMD_NONE));
    check("async_rst.held", 32'(key_held), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset_h = 1'b0;
    watch("rst_rel", 6, CMD_RIGHT, 2, 0, 0, 2);

    // Unmapped code releases with no pulse
    set_kc(8'h05);
    watch("unmapped", 8, CMD_NONE, -1, 0, 0, -1);
    check("unmapped.held", 32'(key_held), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
